// File: rtl/stopwatch_pkg.sv
// Shared widths, default moduli and FSM encoding for the stopwatch time counter.
package stopwatch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int MSEC_MAX_DEF = 100;
  localparam int SEC_MAX_DEF  = 60;
  localparam int MIN_MAX_DEF  = 60;
  localparam int HOUR_MAX_DEF = 24;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef struct packed {
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  mins;
    logic [SEC_W-1:0]  secs;
    logic [MSEC_W-1:0] msecs;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_time_counter_mod_n_counter.sv
// Modulo-N up counter with synchronous clear and a combinational carry-out
// that fires on the increment which wraps N-1 back to 0.
module mod_n_counter #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_carry
);

  logic [WIDTH-1:0] cnt;
  logic             at_max;

  assign at_max  = (cnt == WIDTH'(N - 1));
  assign o_carry = i_inc && at_max;
  assign o_cnt   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_inc) begin
      cnt <= at_max ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time keeper: run/stop/clear FSM driving a cascade of modulo counters.
// Optional lap hold display freeze is enabled with `define STOPWATCH_LAP_HOLD_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MSEC_MAX = MSEC_MAX_DEF,
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick_100hz,
  input  logic              i_run_stop,
  input  logic              i_clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic              i_lap,
`endif
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_running
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              running;
  logic              count_en;
  logic              clr_fields;
  logic              msec_carry;
  logic              sec_carry;
  logic              min_carry;
  logic              hour_carry_unused;
  logic [MSEC_W-1:0] msec_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [MIN_W-1:0]  min_cnt;
  logic [HOUR_W-1:0] hour_cnt;
  sw_time_t          live;
  sw_time_t          shown;

  // Clear wins over run/stop while stopped; inputs are ignored in CLEAR.
  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: begin
        if (i_clear) begin
          state_next = ST_CLEAR;
        end else if (i_run_stop) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_run_stop) begin
          state_next = ST_STOP;
        end
      end
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_STOP;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
    end
  end

  // A tick arriving with a stop pulse in RUN is still counted.
  assign count_en   = (state == ST_RUN) && i_tick_100hz;
  assign clr_fields = (state == ST_CLEAR);

  mod_n_counter #(.N(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (count_en),
    .i_clr   (clr_fields),
    .o_cnt   (msec_cnt),
    .o_carry (msec_carry)
  );

  mod_n_counter #(.N(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (msec_carry),
    .i_clr   (clr_fields),
    .o_cnt   (sec_cnt),
    .o_carry (sec_carry)
  );

  mod_n_counter #(.N(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (sec_carry),
    .i_clr   (clr_fields),
    .o_cnt   (min_cnt),
    .o_carry (min_carry)
  );

  mod_n_counter #(.N(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (min_carry),
    .i_clr   (clr_fields),
    .o_cnt   (hour_cnt),
    .o_carry (hour_carry_unused)
  );

  assign live = {hour_cnt, min_cnt, sec_cnt, msec_cnt};

`ifdef STOPWATCH_LAP_HOLD_EN
  logic     hold;
  sw_time_t cap;

  // Lap freezes the display only; the live counters keep running underneath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      cap  <= '0;
    end else if (state == ST_CLEAR) begin
      hold <= 1'b0;
    end else if (state == ST_RUN && i_run_stop) begin
      hold <= 1'b0;
    end else if (state == ST_RUN && i_lap) begin
      hold <= !hold;
      if (!hold) begin
        cap <= live;
      end
    end
  end

  assign shown = hold ? cap : live;
`else
  assign shown = live;
`endif

  assign {o_hour, o_min, o_sec, o_msec} = shown;
  assign o_running = running;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter: a default-moduli DUT plus a
// small-moduli DUT used to reach the full-wrap boundary in few cycles.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, run_stop = 1'b0, clr = 1'b0;
  logic s_tick = 1'b0, s_run_stop = 1'b0, s_clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap = 1'b0, s_lap = 1'b0;
`endif

  logic [6:0] msec, s_msec;
  logic [5:0] sec, s_sec, min, s_min;
  logic [4:0] hour, s_hour;
  logic       running, s_running;
  logic [24:0] obs, obs_s;

  typedef struct {
    string       name;
    logic [24:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  stopwatch_time_counter dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick_100hz (tick),
    .i_run_stop   (run_stop),
    .i_clear      (clr),
`ifdef STOPWATCH_LAP_HOLD_EN
    .i_lap        (lap),
`endif
    .o_msec       (msec),
    .o_sec        (sec),
    .o_min        (min),
    .o_hour       (hour),
    .o_running    (running)
  );

  stopwatch_time_counter #(.MSEC_MAX(5), .SEC_MAX(3), .MIN_MAX(4), .HOUR_MAX(3)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .i_tick_100hz (s_tick),
    .i_run_stop   (s_run_stop),
    .i_clear      (s_clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .i_lap        (s_lap),
`endif
    .o_msec       (s_msec),
    .o_sec        (s_sec),
    .o_min        (s_min),
    .o_hour       (s_hour),
    .o_running    (s_running)
  );

  assign obs   = {hour, min, sec, msec, running};
  assign obs_s = {s_hour, s_min, s_sec, s_msec, s_running};

  // Expected display for n hundredths of elapsed run time, default moduli.
  function automatic logic [24:0] tv(int n, logic run);
    int m = n % 8640000;
    return {5'((m / 360000) % 24), 6'((m / 6000) % 60), 6'((m / 100) % 60), 7'(m % 100), run};
  endfunction

  // Same model for the 3h x 4m x 3s x 5cs instance.
  function automatic logic [24:0] tv_small(int n, logic run);
    int m = n % 180;
    return {5'((m / 60) % 3), 6'((m / 15) % 4), 6'((m / 5) % 3), 7'(m % 5), run};
  endfunction

  task automatic expect_val(input string name, input logic [24:0] v);
    exp_t x;
    x.name = name;
    x.val  = v;
    exp_q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run_stop = 1'b1; cyc(); run_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
  endtask

  task automatic s_ticks(input int n);
    repeat (n) begin
      s_tick = 1'b1; cyc(); s_tick = 1'b0; cyc();
    end
  endtask

  task automatic test_reset();
    expect_val("reset_values", tv(0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
  endtask

  task automatic test_count();
    pulse_run();
    expect_val("run_start", tv(0, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(150);
    expect_val("count_150", tv(150, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_run();
    expect_val("stop_pulse", tv(150, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(20);
    expect_val("ticks_dropped_in_stop", tv(150, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
  endtask

  task automatic test_clear();
    pulse_run();
    ticks(160);
    expect_val("at_3_10", tv(310, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_clear();
    expect_val("clear_ignored_in_run", tv(310, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_run();
    pulse_clear();
    expect_val("clear_one_cycle_in", tv(310, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    expect_val("clear_done", tv(0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
  endtask

  task automatic test_minute_carry();
    pulse_run();
    ticks(5999);
    expect_val("at_59_99", tv(5999, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(1);
    expect_val("carry_to_minute", tv(6000, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_run();
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    cyc();
    pulse_run();
    ticks(10);
    tick = 1'b1; run_stop = 1'b1; cyc(); tick = 1'b0; run_stop = 1'b0;
    expect_val("tick_and_stop_in_run", tv(11, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(1);
    expect_val("stopped_after_tick_stop", tv(11, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    tick = 1'b1; run_stop = 1'b1; cyc(); tick = 1'b0; run_stop = 1'b0;
    expect_val("tick_and_start_in_stop", tv(11, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(1);
    expect_val("first_tick_after_start", tv(12, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_run();
    clr = 1'b1; run_stop = 1'b1; cyc(); clr = 1'b0; run_stop = 1'b0;
    cyc();
    expect_val("clear_beats_run_stop", tv(0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    ticks(3);
    expect_val("stopped_after_clear", tv(0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
  endtask

  task automatic test_async_reset();
    pulse_run();
    ticks(537);
    expect_val("at_5_37", tv(537, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    #2 rst = 1'b1;
    expect_val("async_reset_immediate", tv(0, 1'b0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    ticks(5);
    expect_val("stop_after_reset", tv(0, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
  endtask

  task automatic test_full_wrap();
    s_run_stop = 1'b1; cyc(); s_run_stop = 1'b0;
    s_ticks(59);
    expect_val("small_before_hour_carry", tv_small(59, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs_s, e.val); else passed++;
    cyc();
    s_ticks(1);
    expect_val("small_hour_carry", tv_small(60, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs_s, e.val); else passed++;
    cyc();
    s_ticks(119);
    expect_val("small_all_max", tv_small(179, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs_s, e.val); else passed++;
    cyc();
    s_ticks(1);
    expect_val("small_full_wrap", tv_small(180, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs_s, e.val); else passed++;
    cyc();
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic test_lap();
    pulse_run();
    ticks(200);
    lap = 1'b1; cyc(); lap = 1'b0;
    ticks(100);
    expect_val("lap_hold", tv(200, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    lap = 1'b1; cyc(); lap = 1'b0;
    expect_val("lap_release", tv(300, 1'b1));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.val); else passed++;
    cyc();
    pulse_run();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    test_reset();
    test_count();
    test_clear();
    test_minute_carry();
    test_simultaneous();
    test_async_reset();
    test_full_wrap();
`ifdef STOPWATCH_LAP_HOLD_EN
    test_lap();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
